// File: rtl/perm_pkg.sv
// perm_pkg: shared state encoding and index-width helper for permutation blocks
package perm_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, EMIT, FAIL} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/perm_seen_tracker.sv
// perm_seen_tracker: bitmap of loaded indices, flags duplicates and out-of-range values
module perm_seen_tracker
    import perm_pkg::*;
#(
    parameter int N = 100,
    parameter int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         set,
    input  logic [W-1:0] idx,
    output logic         bad
);
    localparam logic [W:0] NV = (W+1)'(N);
    logic [N-1:0] seen;
    logic in_range;
    assign in_range = {1'b0, idx} < NV;
    assign bad = !in_range || seen[idx];
    always_ff @(posedge clk) begin
        if (reset || clear)
            seen <= '0;
        else if (set && in_range)
            seen[idx] <= 1'b1;
    end
endmodule

// File: rtl/perm_inverter.sv
// perm_inverter: accepts a permutation in arrival order and streams out its inverse
module perm_inverter
    import perm_pkg::*;
#(
    parameter int N = 100,
    parameter int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_index,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_index,
    output logic         out_last,
    output logic         done,
    output logic         error
);
    localparam logic [W:0] LAST = (W+1)'(N-1);
    state_t state, next_state;
    logic [W:0] count, ptr;
    logic bad, bad_now, xfer, fin_in, fin_out, go;
    logic [W-1:0] inv [N];
    perm_seen_tracker #(.N(N), .W(W)) u_seen (
        .clk(clk),
        .reset(reset),
        .clear(go),
        .set(xfer),
        .idx(in_index),
        .bad(bad_now)
    );
    always_comb begin
        go = state == IDLE && start;
        in_ready = state == LOAD;
        out_valid = state == EMIT;
        xfer = in_ready && in_valid;
        fin_in = xfer && count == LAST;
        out_index = inv[ptr[W-1:0]];
        out_last = out_valid && ptr == LAST;
        fin_out = out_last && out_ready;
        done = fin_out || state == FAIL;
        next_state = state;
        case (state)
            IDLE: next_state = start ? LOAD : IDLE;
            LOAD: next_state = fin_in ? ((bad || bad_now) ? FAIL : EMIT) : LOAD;
            EMIT: next_state = fin_out ? IDLE : EMIT;
            FAIL: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            ptr <= '0;
            bad <= 1'b0;
            error <= 1'b0;
        end else begin
            if (go) begin
                count <= '0;
                ptr <= '0;
                bad <= 1'b0;
                error <= 1'b0;
            end
            if (xfer) begin
                count <= count + 1'b1;
                bad <= bad | bad_now;
            end
            if (out_valid && out_ready)
                ptr <= ptr + 1'b1;
            if (state == FAIL)
                error <= 1'b1;
        end
    end
    // rejected elements never touch inv, so a failed run cannot corrupt earlier slots
    always_ff @(posedge clk) begin
        if (xfer && !bad_now)
            inv[in_index] <= count[W-1:0];
    end
endmodule
